tx_scheduler: RTL and testbench

TX_SCHEDULER -- requirements
Module: tx_scheduler

---
 rtl/tx_scheduler.sv | 165 ++++++++++++++++
 tb/tb_tx_scheduler.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_scheduler.sv
// Schedules register-file reads and ALU results onto a single UART TX byte stream.
// Each source has a one-entry buffer. Ties are granted round-robin, and each byte is handshaked against TX_BUSY.
`timescale 1ns/1ps
module tx_scheduler #(
    parameter int DATA_WIDTH     = 8,
    parameter int HOLD_CYCLES    = 15,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    REF_CLK,
    input  logic                    RST_REF,
    input  logic [DATA_WIDTH-1:0]   RD_DATA,
    input  logic                    RD_DATA_VLD,
    input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
    input  logic                    ALU_OUT_VLD,
    input  logic                    TX_BUSY,
    input  logic                    CLR_ERR,
    output logic [DATA_WIDTH-1:0]   TX_P_DATA,
    output logic                    TX_DATA_VALID,
    output logic                    SCHED_BUSY,
    output logic                    OVERRUN,
    output logic                    TX_TIMEOUT
);

    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, HOLD, WAIT_BUSY, WAIT_DONE} state_t;

    state_t                  state;
    logic [DATA_WIDTH-1:0]   rd_buf;
    logic                    rd_full;
    logic [2*DATA_WIDTH-1:0] alu_buf;
    logic                    alu_full;
    logic [DATA_WIDTH-1:0]   frame_hi;
    logic [1:0]              bytes_left;
    logic                    last_rd;
    logic [HOLD_W-1:0]       hold_cnt;
    logic [TO_W-1:0]         to_cnt;

    logic grant_rd, grant_alu;
    logic rd_capture, alu_capture, rd_drop, alu_drop, timeout_evt;

    // Round-robin: when both buffers are full, the source that was not served last wins.
    always_comb begin
        grant_rd  = 1'b0;
        grant_alu = 1'b0;
        if (state == IDLE) begin
            if (rd_full && alu_full) begin
                grant_alu = last_rd;
                grant_rd  = !last_rd;
            end else begin
                grant_rd  = rd_full;
                grant_alu = alu_full;
            end
        end
    end

    // A buffer that is being granted this cycle counts as free, so a new pulse refills it.
    assign rd_capture  = RD_DATA_VLD && (!rd_full || grant_rd);
    assign rd_drop     = RD_DATA_VLD && rd_full && !grant_rd;
    assign alu_capture = ALU_OUT_VLD && (!alu_full || grant_alu);
    assign alu_drop    = ALU_OUT_VLD && alu_full && !grant_alu;
    assign timeout_evt = (state == WAIT_BUSY) && !TX_BUSY && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    assign SCHED_BUSY  = rd_full || alu_full || (state != IDLE);

    always_ff @(posedge REF_CLK or negedge RST_REF) begin
        if (!RST_REF) begin
            state         <= IDLE;
            rd_buf        <= '0;
            rd_full       <= 1'b0;
            alu_buf       <= '0;
            alu_full      <= 1'b0;
            frame_hi      <= '0;
            bytes_left    <= '0;
            last_rd       <= 1'b1;
            hold_cnt      <= '0;
            to_cnt        <= '0;
            TX_P_DATA     <= '0;
            TX_DATA_VALID <= 1'b0;
            OVERRUN       <= 1'b0;
            TX_TIMEOUT    <= 1'b0;
        end else begin
            if (rd_capture) begin
                rd_buf  <= RD_DATA;
                rd_full <= 1'b1;
            end else if (grant_rd) begin
                rd_full <= 1'b0;
            end

            if (alu_capture) begin
                alu_buf  <= ALU_OUT;
                alu_full <= 1'b1;
            end else if (grant_alu) begin
                alu_full <= 1'b0;
            end

            if (rd_drop || alu_drop) OVERRUN <= 1'b1;
            else if (CLR_ERR)        OVERRUN <= 1'b0;

            if (timeout_evt)  TX_TIMEOUT <= 1'b1;
            else if (CLR_ERR) TX_TIMEOUT <= 1'b0;

            case (state)
                IDLE: begin
                    if (grant_rd) begin
                        TX_P_DATA     <= rd_buf;
                        frame_hi      <= '0;
                        bytes_left    <= 2'd1;
                        last_rd       <= 1'b1;
                        TX_DATA_VALID <= 1'b1;
                        hold_cnt      <= '0;
                        state         <= HOLD;
                    end else if (grant_alu) begin
                        TX_P_DATA     <= alu_buf[DATA_WIDTH-1:0];
                        frame_hi      <= alu_buf[2*DATA_WIDTH-1:DATA_WIDTH];
                        bytes_left    <= 2'd2;
                        last_rd       <= 1'b0;
                        TX_DATA_VALID <= 1'b1;
                        hold_cnt      <= '0;
                        state         <= HOLD;
                    end
                end
                HOLD: begin
                    if (hold_cnt == HOLD_W'(HOLD_CYCLES - 1)) begin
                        TX_DATA_VALID <= 1'b0;
                        hold_cnt      <= '0;
                        to_cnt        <= '0;
                        state         <= WAIT_BUSY;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                WAIT_BUSY: begin
                    if (TX_BUSY) begin
                        to_cnt <= '0;
                        state  <= WAIT_DONE;
                    end else if (timeout_evt) begin
                        bytes_left <= '0;
                        to_cnt     <= '0;
                        state      <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                WAIT_DONE: begin
                    if (!TX_BUSY) begin
                        if (bytes_left > 2'd1) begin
                            TX_P_DATA     <= frame_hi;
                            bytes_left    <= bytes_left - 2'd1;
                            TX_DATA_VALID <= 1'b1;
                            hold_cnt      <= '0;
                            state         <= HOLD;
                        end else begin
                            bytes_left <= '0;
                            state      <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tx_scheduler.sv
// Bench for tx_scheduler: a UART busy model, a byte monitor and a send-order model.
// Directed scenarios are followed by randomized single and simultaneous requests.
`timescale 1ns/1ps
module tb_tx_scheduler;

    localparam int HOLD = 15;
    localparam int TMO  = 255;

    logic        REF_CLK = 1'b0;
    logic        RST_REF;
    logic [7:0]  RD_DATA;
    logic        RD_DATA_VLD;
    logic [15:0] ALU_OUT;
    logic        ALU_OUT_VLD;
    logic        TX_BUSY;
    logic        CLR_ERR;
    logic [7:0]  TX_P_DATA;
    logic        TX_DATA_VALID;
    logic        SCHED_BUSY;
    logic        OVERRUN;
    logic        TX_TIMEOUT;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] sent_q[$];
    int         len_q[$];
    bit         stab_q[$];
    logic [7:0] exp_q[$];

    bit uart_en    = 1'b1;
    bit uart_rand  = 1'b0;
    int uart_delay = 3;
    int uart_len   = 20;
    bit last_alu   = 1'b0;

    tx_scheduler #(.DATA_WIDTH(8), .HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TMO)) dut (
        .REF_CLK(REF_CLK), .RST_REF(RST_REF), .RD_DATA(RD_DATA), .RD_DATA_VLD(RD_DATA_VLD),
        .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD), .TX_BUSY(TX_BUSY), .CLR_ERR(CLR_ERR),
        .TX_P_DATA(TX_P_DATA), .TX_DATA_VALID(TX_DATA_VALID), .SCHED_BUSY(SCHED_BUSY),
        .OVERRUN(OVERRUN), .TX_TIMEOUT(TX_TIMEOUT)
    );

    always #5 REF_CLK = ~REF_CLK;

    // Records every valid pulse: the byte, how long valid stayed high and whether data held still.
    initial begin
        logic [7:0] cur;
        int  len;
        bit  stable;
        bit  prev;
        cur = '0; len = 0; stable = 1'b1; prev = 1'b0;
        forever begin
            @(negedge REF_CLK);
            if (TX_DATA_VALID === 1'b1) begin
                if (!prev) begin
                    cur = TX_P_DATA; len = 1; stable = 1'b1;
                end else begin
                    len++;
                    if (TX_P_DATA !== cur) stable = 1'b0;
                end
            end else if (prev) begin
                sent_q.push_back(cur);
                len_q.push_back(len);
                stab_q.push_back(stable);
            end
            prev = (TX_DATA_VALID === 1'b1);
        end
    end

    // UART transmitter model: busy rises some cycles after valid falls, then drops again.
    initial begin
        bit prev;
        int d;
        int l;
        prev = 1'b0;
        TX_BUSY = 1'b0;
        forever begin
            @(negedge REF_CLK);
            if (uart_en && prev && TX_DATA_VALID === 1'b0) begin
                d = uart_rand ? int'($urandom_range(1, 10)) : uart_delay;
                l = uart_rand ? int'($urandom_range(1, 30)) : uart_len;
                repeat (d) @(negedge REF_CLK);
                TX_BUSY = 1'b1;
                repeat (l) @(negedge REF_CLK);
                TX_BUSY = 1'b0;
            end
            prev = (TX_DATA_VALID === 1'b1);
        end
    end

    task automatic pulse(input bit do_rd, input logic [7:0] rd, input bit do_alu, input logic [15:0] alu);
        @(negedge REF_CLK);
        RD_DATA = rd; RD_DATA_VLD = do_rd; ALU_OUT = alu; ALU_OUT_VLD = do_alu;
        @(negedge REF_CLK);
        RD_DATA_VLD = 1'b0; ALU_OUT_VLD = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 5000; c++) begin
            @(negedge REF_CLK);
            if (SCHED_BUSY === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic clear_log();
        sent_q.delete(); len_q.delete(); stab_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset();
        RST_REF = 1'b0; RD_DATA = '0; RD_DATA_VLD = 1'b0; ALU_OUT = '0; ALU_OUT_VLD = 1'b0; CLR_ERR = 1'b0;
        repeat (3) @(negedge REF_CLK);
        n_checks++;
        if ({TX_P_DATA, TX_DATA_VALID, SCHED_BUSY, OVERRUN, TX_TIMEOUT} !== 12'h0)
            $display("[TB] FAIL reset_outputs: got %h expected 000", {TX_P_DATA, TX_DATA_VALID, SCHED_BUSY, OVERRUN, TX_TIMEOUT});
        else n_pass++;
        RST_REF = 1'b1;
        repeat (3) @(negedge REF_CLK);
        n_checks++;
        if ({TX_P_DATA, TX_DATA_VALID, SCHED_BUSY, OVERRUN, TX_TIMEOUT} !== 12'h0)
            $display("[TB] FAIL post_reset_idle: got %h expected 000", {TX_P_DATA, TX_DATA_VALID, SCHED_BUSY, OVERRUN, TX_TIMEOUT});
        else n_pass++;
        last_alu = 1'b0;
    endtask

    task automatic test_pair_after_reset();
        bit ok;
        clear_log();
        pulse(1'b1, 8'h11, 1'b1, 16'hBEEF);
        wait_idle(ok);
        n_checks++;
        if (!ok) $display("[TB] FAIL pair_idle: got busy expected idle"); else n_pass++;
        exp_q = '{8'hEF, 8'hBE, 8'h11};
        last_alu = 1'b0;
        n_checks++;
        if (sent_q.size() != exp_q.size()) $display("[TB] FAIL pair_count: got %0d expected %0d", sent_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < sent_q.size(); i++) begin
            n_checks++;
            if (sent_q[i] !== exp_q[i] || len_q[i] != HOLD || !stab_q[i])
                $display("[TB] FAIL pair_byte%0d: got %h len %0d stable %0d expected %h len %0d stable 1",
                         i, sent_q[i], len_q[i], stab_q[i], exp_q[i], HOLD);
            else n_pass++;
        end
        n_checks++;
        if (OVERRUN !== 1'b0) $display("[TB] FAIL pair_overrun: got %b expected 0", OVERRUN); else n_pass++;
    endtask

    task automatic test_rd_single();
        bit ok;
        clear_log();
        uart_rand = 1'b0; uart_delay = 3; uart_len = 20;
        pulse(1'b1, 8'hA5, 1'b0, 16'h0);
        n_checks++;
        if (SCHED_BUSY !== 1'b1) $display("[TB] FAIL rd_busy_rise: got %b expected 1", SCHED_BUSY); else n_pass++;
        wait_idle(ok);
        n_checks++;
        if (!ok) $display("[TB] FAIL rd_idle: got busy expected idle"); else n_pass++;
        n_checks++;
        if (sent_q.size() != 1 || sent_q[0] !== 8'hA5 || len_q[0] != HOLD || !stab_q[0])
            $display("[TB] FAIL rd_byte: got %0d bytes first %h len %0d expected 1 byte a5 len %0d",
                     sent_q.size(), sent_q.size() > 0 ? sent_q[0] : 8'h00, len_q.size() > 0 ? len_q[0] : 0, HOLD);
        else n_pass++;
        n_checks++;
        if (TX_P_DATA !== 8'hA5) $display("[TB] FAIL rd_retain: got %h expected a5", TX_P_DATA); else n_pass++;
        last_alu = 1'b0;
    endtask

    task automatic test_alu_single();
        bit ok;
        clear_log();
        pulse(1'b0, 8'h00, 1'b1, 16'h1234);
        wait_idle(ok);
        n_checks++;
        if (!ok) $display("[TB] FAIL alu_idle: got busy expected idle"); else n_pass++;
        exp_q = '{8'h34, 8'h12};
        last_alu = 1'b1;
        n_checks++;
        if (sent_q.size() != exp_q.size()) $display("[TB] FAIL alu_count: got %0d expected %0d", sent_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < sent_q.size(); i++) begin
            n_checks++;
            if (sent_q[i] !== exp_q[i] || len_q[i] != HOLD || !stab_q[i])
                $display("[TB] FAIL alu_byte%0d: got %h len %0d stable %0d expected %h len %0d stable 1",
                         i, sent_q[i], len_q[i], stab_q[i], exp_q[i], HOLD);
            else n_pass++;
        end
    endtask

    task automatic test_overrun();
        bit ok;
        clear_log();
        pulse(1'b0, 8'h00, 1'b1, 16'h5678);
        pulse(1'b1, 8'h11, 1'b0, 16'h0);
        pulse(1'b1, 8'h22, 1'b0, 16'h0);
        n_checks++;
        if (OVERRUN !== 1'b1) $display("[TB] FAIL overrun_set: got %b expected 1", OVERRUN); else n_pass++;
        wait_idle(ok);
        n_checks++;
        if (!ok) $display("[TB] FAIL overrun_idle: got busy expected idle"); else n_pass++;
        exp_q = '{8'h78, 8'h56, 8'h11};
        last_alu = 1'b0;
        n_checks++;
        if (sent_q.size() != exp_q.size()) $display("[TB] FAIL overrun_count: got %0d expected %0d", sent_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < sent_q.size(); i++) begin
            n_checks++;
            if (sent_q[i] !== exp_q[i]) $display("[TB] FAIL overrun_byte%0d: got %h expected %h", i, sent_q[i], exp_q[i]);
            else n_pass++;
        end
        n_checks++;
        if (OVERRUN !== 1'b1) $display("[TB] FAIL overrun_sticky: got %b expected 1", OVERRUN); else n_pass++;
        @(negedge REF_CLK); CLR_ERR = 1'b1;
        @(negedge REF_CLK); CLR_ERR = 1'b0;
        n_checks++;
        if (OVERRUN !== 1'b0) $display("[TB] FAIL overrun_clear: got %b expected 0", OVERRUN); else n_pass++;
    endtask

    task automatic test_timeout();
        bit ok;
        int cnt;
        clear_log();
        uart_en = 1'b0;
        pulse(1'b1, 8'h3C, 1'b0, 16'h0);
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge REF_CLK);
            if (TX_DATA_VALID === 1'b1) begin ok = 1'b1; break; end
        end
        if (ok) begin
            ok = 1'b0;
            for (int c = 0; c < 100; c++) begin
                @(negedge REF_CLK);
                if (TX_DATA_VALID === 1'b0) begin ok = 1'b1; break; end
            end
        end
        n_checks++;
        if (!ok) $display("[TB] FAIL timeout_valid_pulse: got no pulse expected one"); else n_pass++;
        cnt = 0;
        while (TX_TIMEOUT !== 1'b1 && cnt < 400) begin
            @(negedge REF_CLK);
            cnt++;
        end
        n_checks++;
        if (cnt != TMO) $display("[TB] FAIL timeout_latency: got %0d cycles expected %0d", cnt, TMO); else n_pass++;
        n_checks++;
        if (SCHED_BUSY !== 1'b0) $display("[TB] FAIL timeout_idle: got %b expected 0", SCHED_BUSY); else n_pass++;
        uart_en = 1'b1;
        clear_log();
        pulse(1'b1, 8'h5A, 1'b0, 16'h0);
        wait_idle(ok);
        n_checks++;
        if (!ok || sent_q.size() != 1 || sent_q[0] !== 8'h5A || len_q[0] != HOLD)
            $display("[TB] FAIL timeout_next_req: got %0d bytes first %h expected 1 byte 5a",
                     sent_q.size(), sent_q.size() > 0 ? sent_q[0] : 8'h00);
        else n_pass++;
        last_alu = 1'b0;
        n_checks++;
        if (TX_TIMEOUT !== 1'b1) $display("[TB] FAIL timeout_sticky: got %b expected 1", TX_TIMEOUT); else n_pass++;
        @(negedge REF_CLK); CLR_ERR = 1'b1;
        @(negedge REF_CLK); CLR_ERR = 1'b0;
        n_checks++;
        if (TX_TIMEOUT !== 1'b0) $display("[TB] FAIL timeout_clear: got %b expected 0", TX_TIMEOUT); else n_pass++;
    endtask

    // Expected order: a lone request goes out alone; a simultaneous pair starts with whoever was not served last.
    task automatic test_random();
        bit ok;
        int mode;
        logic [7:0]  rd;
        logic [15:0] alu;
        uart_rand = 1'b1;
        for (int it = 0; it < 12; it++) begin
            clear_log();
            mode = int'($urandom_range(0, 2));
            rd   = 8'($urandom);
            alu  = 16'($urandom);
            if (mode == 0) begin
                exp_q = '{rd};
                last_alu = 1'b0;
            end else if (mode == 1) begin
                exp_q = '{alu[7:0], alu[15:8]};
                last_alu = 1'b1;
            end else if (!last_alu) begin
                exp_q = '{alu[7:0], alu[15:8], rd};
                last_alu = 1'b0;
            end else begin
                exp_q = '{rd, alu[7:0], alu[15:8]};
                last_alu = 1'b1;
            end
            pulse(mode != 1, rd, mode != 0, alu);
            wait_idle(ok);
            n_checks++;
            if (!ok || sent_q.size() != exp_q.size())
                $display("[TB] FAIL rand%0d_count: got %0d bytes idle %0d expected %0d bytes", it, sent_q.size(), ok, exp_q.size());
            else n_pass++;
            for (int i = 0; i < exp_q.size() && i < sent_q.size(); i++) begin
                n_checks++;
                if (sent_q[i] !== exp_q[i] || len_q[i] != HOLD || !stab_q[i])
                    $display("[TB] FAIL rand%0d_byte%0d: got %h len %0d stable %0d expected %h len %0d stable 1",
                             it, i, sent_q[i], len_q[i], stab_q[i], exp_q[i], HOLD);
                else n_pass++;
            end
            n_checks++;
            if (OVERRUN !== 1'b0) $display("[TB] FAIL rand%0d_overrun: got %b expected 0", it, OVERRUN); else n_pass++;
        end
        uart_rand = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        clear_log();
        pulse(1'b0, 8'h00, 1'b1, 16'h1234);
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge REF_CLK);
            if (TX_DATA_VALID === 1'b1) begin ok = 1'b1; break; end
        end
        n_checks++;
        if (!ok) $display("[TB] FAIL midreset_hold: got no valid expected valid"); else n_pass++;
        pulse(1'b0, 8'h00, 1'b1, 16'hAAAA);
        pulse(1'b0, 8'h00, 1'b1, 16'hBBBB);
        n_checks++;
        if (OVERRUN !== 1'b1 || TX_DATA_VALID !== 1'b1)
            $display("[TB] FAIL midreset_pre: got overrun %b valid %b expected 1 1", OVERRUN, TX_DATA_VALID);
        else n_pass++;
        uart_en = 1'b0;
        #2 RST_REF = 1'b0;
        #1;
        n_checks++;
        if ({TX_P_DATA, TX_DATA_VALID, SCHED_BUSY, OVERRUN, TX_TIMEOUT} !== 12'h0)
            $display("[TB] FAIL midreset_async: got %h expected 000", {TX_P_DATA, TX_DATA_VALID, SCHED_BUSY, OVERRUN, TX_TIMEOUT});
        else n_pass++;
        repeat (2) @(negedge REF_CLK);
        clear_log();
        RST_REF = 1'b1;
        last_alu = 1'b0;
        uart_en = 1'b1;
        repeat (100) @(negedge REF_CLK);
        n_checks++;
        if (sent_q.size() != 0 || SCHED_BUSY !== 1'b0)
            $display("[TB] FAIL midreset_no_resend: got %0d bytes busy %b expected 0 bytes busy 0", sent_q.size(), SCHED_BUSY);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_pair_after_reset();
        test_rd_single();
        test_alu_single();
        test_overrun();
        test_timeout();
        test_random();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
